// File: rtl/de0_clkgen.sv
// PLL lock qualifier and clock-enable generator for the clkin domain.
// Produces a lock-qualified system reset plus CHANNELS phase-aligned, reprogrammable CE strobes.
module de0_clkgen #(
  parameter int CHANNELS    = 4,
  parameter int DIV_W       = 16,
  parameter int DIV_INIT    = 1,
  parameter int LOCK_STABLE = 1024,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clkin,
  input  logic                rst,
  input  logic                locked_in,
  input  logic                div_we,
  input  logic [SEL_W-1:0]    div_sel,
  input  logic [DIV_W-1:0]    div_val,
  input  logic                lost_clr,
  output logic                sys_rst_n,
  output logic                ready,
  output logic [CHANNELS-1:0] ce_out,
  output logic                lock_lost
);

  localparam int STAB_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [STAB_W-1:0]      stab_q, stab_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lost_q, lost_d;
  logic                   locked_s;
  logic                   run_q;

  assign locked_s  = sync_q[SYNC_STAGES-1];
  assign run_q     = (state_q == RUN);
  assign ready     = run_q;
  assign sys_rst_n = run_q;
  assign lock_lost = lost_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], locked_in};
    state_d = state_q;
    stab_d  = stab_q;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: if (locked_s) begin
        state_d = STABLE;
        stab_d  = '0;
      end
      STABLE: begin
        if (!locked_s)               state_d = WAIT_LOCK;
        else if (stab_q == STAB_LAST) state_d = RUN;
        else                          stab_d  = stab_q + 1'b1;
      end
      RUN: if (!locked_s) state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
    // Losing lock after qualification outranks a simultaneous clear.
    if (run_q && !locked_s) lost_d = 1'b1;
    else if (lost_clr)      lost_d = 1'b0;
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      sync_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      sync_q  <= sync_d;
      lost_q  <= lost_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] shd_q, shd_d;
    logic             short_div;
    logic             at_last;

    // The shadow only reaches the active divisor at a period boundary, so periods never get cut short.
    always_comb begin
      shd_d = shd_q;
      if (div_we && (div_sel == SEL_W'(gi))) shd_d = div_val;
      short_div = (div_q <= DIV_W'(1));
      at_last   = (cnt_q == div_q - DIV_W'(1));
      div_d     = (!run_q || short_div || at_last) ? shd_d : div_q;
      cnt_d     = '0;
      if (run_q && (state_d == RUN) && !short_div && !at_last) cnt_d = cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clkin or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        div_q <= DIV_W'(DIV_INIT);
        shd_q <= DIV_W'(DIV_INIT);
      end else begin
        cnt_q <= cnt_d;
        div_q <= div_d;
        shd_q <= shd_d;
      end
    end

    assign ce_out[gi] = run_q && (cnt_q == '0);
  end

endmodule
